// File: rtl/ram_sp_arbiter_if.sv
// Requester-side command/response bundle for the shared single-port RAM arbiter.
// The requester (master) drives the command fields. The arbiter (slave) returns
// the grant and read data.
interface ram_sp_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/ram_sp_arbiter.sv
// Two-requester round-robin arbiter sharing one synchronous-write /
// asynchronous-read RAM. The grant is combinational from registered pointer
// and lock state. The RAM port is driven from registered command state, and
// read data returns one edge later with a single-cycle rvalid pulse.
module ram_sp_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_sp_arbiter_if.slave   port_a,
    ram_sp_arbiter_if.slave   port_b,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_en,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    pri_e              pri_q, pri_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              ram_write_en_q, ram_write_en_d;
    logic              rd_pend_a_q, rd_pend_a_d;
    logic              rd_pend_b_q, rd_pend_b_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              gnt_a, gnt_b;

    // Arbitration: the lock owner is exclusive, otherwise a lone requester
    // wins and a tie goes to the pointer holder. Reset gates the grants off.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (reset_n) begin
            case (owner_q)
                OWN_A: gnt_a = port_a.req;
                OWN_B: gnt_b = port_b.req;
                default: begin
                    if (port_a.req && port_b.req) begin
                        gnt_a = (pri_q == PRI_A);
                        gnt_b = (pri_q == PRI_B);
                    end else begin
                        gnt_a = port_a.req;
                        gnt_b = port_b.req;
                    end
                end
            endcase
        end
    end

    // Next state: pointer and lock bookkeeping, RAM command capture and the
    // read-return pipeline stage.
    always_comb begin
        pri_d          = pri_q;
        owner_d        = owner_q;
        ram_address_d  = ram_address_q;
        ram_data_in_d  = ram_data_in_q;
        ram_write_en_d = 1'b0;
        rd_pend_a_d    = 1'b0;
        rd_pend_b_d    = 1'b0;
        rvalid_a_d     = rd_pend_a_q;
        rvalid_b_d     = rd_pend_b_q;
        rdata_a_d      = rd_pend_a_q ? ram_data_out : rdata_a_q;
        rdata_b_d      = rd_pend_b_q ? ram_data_out : rdata_b_q;

        if (gnt_a) begin
            pri_d          = PRI_B;
            ram_address_d  = port_a.addr;
            ram_data_in_d  = port_a.wdata;
            ram_write_en_d = port_a.we;
            rd_pend_a_d    = !port_a.we;
            if (port_a.lock) begin
                owner_d = OWN_A;
            end else if (owner_q == OWN_A) begin
                owner_d = OWN_NONE;
            end
        end else if (gnt_b) begin
            pri_d          = PRI_A;
            ram_address_d  = port_b.addr;
            ram_data_in_d  = port_b.wdata;
            ram_write_en_d = port_b.we;
            rd_pend_b_d    = !port_b.we;
            if (port_b.lock) begin
                owner_d = OWN_B;
            end else if (owner_q == OWN_B) begin
                owner_d = OWN_NONE;
            end
        end
    end

    // State registers. Reset discards any in-flight command before it can
    // reach the RAM write edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pri_q          <= PRI_A;
            owner_q        <= OWN_NONE;
            ram_address_q  <= '0;
            ram_data_in_q  <= '0;
            ram_write_en_q <= 1'b0;
            rd_pend_a_q    <= 1'b0;
            rd_pend_b_q    <= 1'b0;
            rvalid_a_q     <= 1'b0;
            rvalid_b_q     <= 1'b0;
            rdata_a_q      <= '0;
            rdata_b_q      <= '0;
        end else begin
            pri_q          <= pri_d;
            owner_q        <= owner_d;
            ram_address_q  <= ram_address_d;
            ram_data_in_q  <= ram_data_in_d;
            ram_write_en_q <= ram_write_en_d;
            rd_pend_a_q    <= rd_pend_a_d;
            rd_pend_b_q    <= rd_pend_b_d;
            rvalid_a_q     <= rvalid_a_d;
            rvalid_b_q     <= rvalid_b_d;
            rdata_a_q      <= rdata_a_d;
            rdata_b_q      <= rdata_b_d;
        end
    end

    assign port_a.gnt    = gnt_a;
    assign port_b.gnt    = gnt_b;
    assign port_a.rdata  = rdata_a_q;
    assign port_b.rdata  = rdata_b_q;
    assign port_a.rvalid = rvalid_a_q;
    assign port_b.rvalid = rvalid_b_q;
    assign ram_address   = ram_address_q;
    assign ram_data_in   = ram_data_in_q;
    assign ram_write_en  = ram_write_en_q;

endmodule
